// File: rtl/converter_pkg.sv
// Shared word/counter types for the serial<->parallel converter stages.
// Pure types and constants; no logic, no latency.
// Imported by both the serial-to-parallel and parallel-to-serial stages.
package converter_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int CNT_WIDTH  = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  // Bits needed to index an array of n entries (never less than one).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/s_to_p_converter_if.sv
// Upstream group bus plus downstream frame bus of the serial-to-parallel stage.
// Wires only; no latency.
// fct throttles upstream, dfull throttles the frame output.
interface s_to_p_converter_if
  import converter_pkg::*;
#(
  parameter int PARALLEL_LENGTH = 32,
  parameter int SERIAL_LENGTH   = 1
) ();

  logic                            ien;
  word_t [0:SERIAL_LENGTH-1]       idata;
  logic                            fct;
  logic                            oen;
  word_t [0:PARALLEL_LENGTH-1]     odata;
  logic                            dfull;

  // Environment side: supplies groups and the downstream full flag.
  modport master (
    output ien, idata, dfull,
    input  fct, oen, odata
  );

  // Converter side.
  modport slave (
    input  ien, idata, dfull,
    output fct, oen, odata
  );

endinterface

// File: rtl/s_to_p_converter.sv
// Packs SERIAL_LENGTH-word groups into PARALLEL_LENGTH-word frames, double-buffered (fill + hold).
// Latency: last group accepted at edge E0, transfer to hold at E1, oen high after E2.
// Backpressure: fct = fill buffer full; dfull stalls issue; oen never fires on consecutive cycles.
module s_to_p_converter
  import converter_pkg::*;
#(
  parameter int PARALLEL_LENGTH = 32,
  parameter int SERIAL_LENGTH   = 1
) (
  input logic               clk,
  input logic               rst_n,
  s_to_p_converter_if.slave bus
);

  localparam int   IDXW     = idx_width(PARALLEL_LENGTH);
  localparam cnt_t LAST_CNT = cnt_t'(PARALLEL_LENGTH - SERIAL_LENGTH);
  localparam cnt_t STEP     = cnt_t'(SERIAL_LENGTH);

  cnt_t                        cnt;
  logic                        fill_done;
  logic                        hold_valid;
  logic                        oen_q;
  word_t [0:PARALLEL_LENGTH-1] fill_buf;
  word_t [0:PARALLEL_LENGTH-1] hold_buf;
  word_t [0:PARALLEL_LENGTH-1] odata_q;

  logic accept;
  logic issue;
  logic transfer;

  // A full fill buffer is the only reason to refuse a group; fct never depends on ien.
  assign accept   = bus.ien & ~fill_done;
  // The oen guard keeps pulses two cycles apart, covering the one-cycle lag of dfull.
  assign issue    = hold_valid & ~bus.dfull & ~oen_q;
  // Hold may be refilled in the same cycle it is emptied by an issue.
  assign transfer = fill_done & (~hold_valid | issue);

  assign bus.fct   = fill_done;
  assign bus.oen   = oen_q;
  assign bus.odata = odata_q;

  // Fill counter and buffer/handshake state flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      fill_done  <= 1'b0;
      hold_valid <= 1'b0;
      oen_q      <= 1'b0;
    end else begin
      // accept and transfer are mutually exclusive (accept needs !fill_done).
      if (accept) begin
        if (cnt == LAST_CNT) begin
          cnt       <= '0;
          fill_done <= 1'b1;
        end else begin
          cnt <= cnt + STEP;
        end
      end else if (transfer) begin
        fill_done <= 1'b0;
      end

      if (transfer) begin
        hold_valid <= 1'b1;
      end else if (issue) begin
        hold_valid <= 1'b0;
      end

      oen_q <= issue;
    end
  end

  // Fill buffer: word i of an accepted group lands at frame index cnt+i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_buf <= '0;
    end else if (accept) begin
      for (int i = 0; i < SERIAL_LENGTH; i++) begin
        fill_buf[IDXW'(int'(cnt) + i)] <= bus.idata[i];
      end
    end
  end

  // Hold register and output frame; odata keeps the last issued frame between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_buf <= '0;
      odata_q  <= '0;
    end else begin
      if (transfer) begin
        hold_buf <= fill_buf;
      end
      if (issue) begin
        odata_q <= hold_buf;
      end
    end
  end

endmodule
